arith_reducef_sum: RTL and testbench

- Sequential floating-point sum-reduction stage that sits directly downstream of the floating-point multiply unit.
- Consumes a valid/ready stream of products and folds a runtime-specified number of them into one sum; together with the multiplier it forms a dot-product / multiply-accumulate path.
- Emits one result per reduction on a valid/ready output with the same handshake style as the arithmetic units.

---
 rtl/arith_reducef_sum.sv | 151 +++++++++++++++
 tb/tb_arith_reducef_sum.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_reducef_sum.sv
// Sequential floating-point sum reduction: folds N streamed IEEE elements into one
// sum in strict arrival order and hands it out on a valid/ready result port.
module arith_reducef_sum #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             len_valid,
  output logic             len_ready,
  input  logic [CNT_W-1:0] len_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $fatal(1, "arith_reducef_sum: WIDTH must be 32 or 64");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, EMIT = 2'd2} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] remaining_r;
  logic             first_r;
  logic [WIDTH-1:0] sum_s;

  // Widening binary32 -> binary64 is exact; subnormals are renormalised.
  function automatic logic [63:0] f32_to_f64(input logic [31:0] f);
    logic [63:0] r;
    logic [51:0] mm;
    int          p;
    r = {f[31], 63'd0};
    if (f[30:23] == 8'hFF) begin
      r = {f[31], 11'h7FF, f[22:0], 29'd0};
    end else if (f[30:23] == 8'd0 && f[22:0] == 23'd0) begin
      r = {f[31], 63'd0};
    end else if (f[30:23] == 8'd0) begin
      p = 0;
      for (int i = 0; i < 23; i++) begin
        if (f[i]) p = i;
      end
      mm = 52'(52'(f[22:0]) << (52 - p));
      r  = {f[31], 11'(p + 874), mm};
    end else begin
      r = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    end
    return r;
  endfunction

  // Narrowing binary64 -> binary32 with round-to-nearest-even. A sum of two
  // binary32 values computed in binary64 and rounded once more is still exact RNE.
  function automatic logic [31:0] f64_to_f32(input logic [63:0] d);
    logic [31:0] r;
    logic [63:0] sig, q, rem, half, mag;
    int          biased, sh, eb;
    r = {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) begin
      if (d[51:0] == 52'd0) r = {d[63], 8'hFF, 23'd0};
      else                  r = {d[63], 8'hFF, d[51:29] | 23'h400000};
    end else if (d[62:52] == 11'd0) begin
      r = {d[63], 31'd0};
    end else begin
      biased = int'(d[62:52]) - 896;
      sh = (biased < 1) ? (30 - biased) : 29;
      if (sh > 63) sh = 63;
      sig  = {11'd0, 1'b1, d[51:0]};
      q    = sig >> sh;
      rem  = sig & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      // The implicit bit of q carries into the exponent field, so rounding
      // overflow and subnormal-to-normal promotion fall out of the addition.
      eb  = (biased >= 1) ? (biased - 1) : 0;
      mag = (64'(eb) << 23) + q;
      if (mag >= 64'h7F80_0000) r = {d[63], 8'hFF, 23'd0};
      else                      r = {d[63], mag[30:0]};
    end
    return r;
  endfunction

  if (WIDTH == 32) begin : g_f32
    assign sum_s = f64_to_f32($realtobits($bitstoreal(f32_to_f64(acc_r)) +
                                          $bitstoreal(f32_to_f64(in_data))));
  end else begin : g_f64
    assign sum_s = $realtobits($bitstoreal(acc_r) + $bitstoreal(in_data));
  end

  assign result_data = acc_r;

  // Reduction FSM with registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      acc_r        <= '0;
      remaining_r  <= '0;
      first_r      <= 1'b0;
      len_ready    <= 1'b1;
      in_ready     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (len_valid) begin
            len_ready <= 1'b0;
            if (len_data == '0) begin
              state_r      <= EMIT;
              acc_r        <= '0;
              result_valid <= 1'b1;
            end else begin
              state_r     <= ACC;
              remaining_r <= len_data;
              first_r     <= 1'b1;
              in_ready    <= 1'b1;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            acc_r       <= first_r ? in_data : sum_s;
            first_r     <= 1'b0;
            remaining_r <= remaining_r - CNT_W'(1);
            if (remaining_r == CNT_W'(1)) begin
              state_r      <= EMIT;
              in_ready     <= 1'b0;
              result_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (result_ready) begin
            state_r      <= IDLE;
            result_valid <= 1'b0;
            len_ready    <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          len_ready    <= 1'b1;
          in_ready     <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_reducef_sum.sv
// Scoreboard bench for arith_reducef_sum: binary32 and binary64 instances, directed
// vectors with hand-computed sums, monitors pop expected results on each result fire.
module tb_arith_reducef_sum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        len_valid, len_ready, in_valid, in_ready, result_valid, result_ready;
  logic [15:0] len_data;
  logic [31:0] in_data, result_data;
  logic        len_valid64, len_ready64, in_valid64, in_ready64, result_valid64, result_ready64;
  logic [15:0] len_data64;
  logic [63:0] in_data64, result_data64;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q32[$];
  logic [63:0] exp_q64[$];

  arith_reducef_sum #(.WIDTH(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst),
    .len_valid(len_valid), .len_ready(len_ready), .len_data(len_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data)
  );

  arith_reducef_sum #(.WIDTH(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst),
    .len_valid(len_valid64), .len_ready(len_ready64), .len_data(len_data64),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_data(in_data64),
    .result_valid(result_valid64), .result_ready(result_ready64), .result_data(result_data64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout, handshake never offered ready", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // f32 monitor: every result fire pops one expected sum.
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      if (exp_q32.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL f32 unexpected result: got %h, expected none", result_data);
      end else begin
        check("f32 result", 64'(result_data), 64'(exp_q32.pop_front()));
      end
    end
  end

  // f64 monitor.
  always @(negedge clk) begin
    if (!rst && result_valid64 && result_ready64) begin
      if (exp_q64.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL f64 unexpected result: got %h, expected none", result_data64);
      end else begin
        check("f64 result", result_data64, exp_q64.pop_front());
      end
    end
  end

  task automatic give_len(input logic [15:0] n);
    bit ok = 1'b0;
    len_valid = 1'b1;
    len_data  = n;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (len_ready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("f32 len");
    step();
    len_valid = 1'b0;
  endtask

  task automatic give_elem(input logic [31:0] x, input int bubbles);
    bit ok = 1'b0;
    for (int b = 0; b < bubbles; b++) step();
    in_valid = 1'b1;
    in_data  = x;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("f32 elem");
    step();
    in_valid = 1'b0;
  endtask

  task automatic give_len64(input logic [15:0] n);
    bit ok = 1'b0;
    len_valid64 = 1'b1;
    len_data64  = n;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (len_ready64) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("f64 len");
    step();
    len_valid64 = 1'b0;
  endtask

  task automatic give_elem64(input logic [63:0] x);
    bit ok = 1'b0;
    in_valid64 = 1'b1;
    in_data64  = x;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready64) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("f64 elem");
    step();
    in_valid64 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    len_valid = 1'b0; len_data = 16'd0; in_valid = 1'b0; in_data = 32'd0; result_ready = 1'b1;
    len_valid64 = 1'b0; len_data64 = 16'd0; in_valid64 = 1'b0; in_data64 = 64'd0;
    result_ready64 = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    @(negedge clk);
    check("reset len_ready", 64'(len_ready), 64'd1);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset result_valid", 64'(result_valid), 64'd0);
    check("reset result_data", 64'(result_data), 64'd0);
    step();

    // 1.0 + 2.0 + 3.5 = 6.5, result_valid the cycle after the third fire
    exp_q32.push_back(32'h40D0_0000);
    give_len(16'd3);
    give_elem(32'h3F80_0000, 0);
    give_elem(32'h4000_0000, 0);
    give_elem(32'h4060_0000, 0);
    @(negedge clk);
    check("latency result_valid", 64'(result_valid), 64'd1);
    step();

    // N = 0 goes straight to EMIT with +0.0 and never raises in_ready
    exp_q32.push_back(32'h0000_0000);
    give_len(16'd0);
    @(negedge clk);
    check("len0 result_valid", 64'(result_valid), 64'd1);
    check("len0 in_ready", 64'(in_ready), 64'd0);
    step();

    // -0.0 preserved
    exp_q32.push_back(32'h8000_0000);
    give_len(16'd2);
    give_elem(32'h8000_0000, 0);
    give_elem(32'h8000_0000, 0);

    // Left fold with ties-to-even: ((2^24 + 1) + 1) + 2 = 2^24 + 2
    exp_q32.push_back(32'h4B80_0001);
    give_len(16'd4);
    give_elem(32'h4B80_0000, 0);
    give_elem(32'h3F80_0000, 0);
    give_elem(32'h3F80_0000, 0);
    give_elem(32'h4000_0000, 0);

    // 3.0 + -5.0 = -2.0
    exp_q32.push_back(32'hC000_0000);
    give_len(16'd2);
    give_elem(32'h4040_0000, 0);
    give_elem(32'hC0A0_0000, 0);

    // Same sums with random input bubbles
    exp_q32.push_back(32'h40D0_0000);
    give_len(16'd3);
    give_elem(32'h3F80_0000, int'($urandom_range(0, 3)));
    give_elem(32'h4000_0000, int'($urandom_range(0, 3)));
    give_elem(32'h4060_0000, int'($urandom_range(0, 3)));
    exp_q32.push_back(32'h4B80_0001);
    give_len(16'd4);
    give_elem(32'h4B80_0000, int'($urandom_range(0, 3)));
    give_elem(32'h3F80_0000, int'($urandom_range(0, 3)));
    give_elem(32'h3F80_0000, int'($urandom_range(0, 3)));
    give_elem(32'h4000_0000, int'($urandom_range(0, 3)));
    step();

    // Back-pressure: result held 5 cycles, fires on the first ready cycle
    result_ready = 1'b0;
    exp_q32.push_back(32'h3F80_0000);
    give_len(16'd1);
    give_elem(32'h3F80_0000, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp result_valid", 64'(result_valid), 64'd1);
      check("bp result_data", 64'(result_data), 64'h3F80_0000);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp len_ready", 64'(len_ready), 64'd0);
    end
    step();
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp after fire result_valid", 64'(result_valid), 64'd0);
    check("bp after fire len_ready", 64'(len_ready), 64'd1);
    step();

    // Reset mid-reduction discards the partial sum
    give_len(16'd4);
    give_elem(32'h3F80_0000, 0);
    give_elem(32'h4000_0000, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid reset len_ready", 64'(len_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid reset no result", 64'(result_valid), 64'd0);
    end
    step();
    exp_q32.push_back(32'h4000_0000);
    give_len(16'd1);
    give_elem(32'h4000_0000, 0);

    // binary64: 1.5 + 2.5 = 4.0; 1 + 2^-53 + 2^-53 ties to even at each step
    exp_q64.push_back(64'h4010_0000_0000_0000);
    give_len64(16'd2);
    give_elem64(64'h3FF8_0000_0000_0000);
    give_elem64(64'h4004_0000_0000_0000);
    exp_q64.push_back(64'h3FF0_0000_0000_0000);
    give_len64(16'd3);
    give_elem64(64'h3FF0_0000_0000_0000);
    give_elem64(64'h3CA0_0000_0000_0000);
    give_elem64(64'h3CA0_0000_0000_0000);

    repeat (10) step();
    check("f32 scoreboard drained", 64'(exp_q32.size()), 64'd0);
    check("f64 scoreboard drained", 64'(exp_q64.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
